// File: rtl/usb_tx_bitstuffer.sv
// USB full-speed transmit serialiser with bit stuffing, feeding the NRZI encoder.
// Optional stuffed-bit counter output is enabled by defining USB_STUFF_CNT_EN.
module usb_tx_bitstuffer #(
  parameter int CLK_DIV    = 4,
  parameter int ONES_LIMIT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       bit_valid,
  output logic       bit_out,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_err
`ifdef USB_STUFF_CNT_EN
  ,
  output logic [7:0] stuff_cnt
`endif
);

  localparam int            OW       = $clog2(ONES_LIMIT + 1);
  localparam logic [OW-1:0] LIM      = OW'(ONES_LIMIT);
  localparam logic [4:0]    DIV_LAST = 5'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, STUFF, FINISH} state_t;

  state_t        state;
  logic [7:0]    hold, sh;
  logic          hold_last, hold_full, cur_last, empty, last_taken, final_sent;
  logic [2:0]    idx;
  logic [OW-1:0] ones;
  logic [4:0]    div;

  logic          tick, accept, start, underrun, reload, consume, stuff_now, src_last;
  logic [7:0]    src;
  logic [2:0]    eff_idx;
  logic [OW-1:0] ones_n;

  assign tx_ready  = rst && !hold_full && !last_taken;
  assign accept    = tx_valid && tx_ready;
  assign tick      = (state != IDLE) && (div == 5'd0);
  assign start     = (state == IDLE) && (hold_full || accept);
  // When the shifter is exhausted, the next byte is taken straight from hold.
  assign src       = empty ? hold : sh;
  assign src_last  = empty ? hold_last : cur_last;
  assign eff_idx   = empty ? 3'd0 : idx;
  assign ones_n    = src[0] ? ones + 1'b1 : '0;
  assign stuff_now = (ones_n == LIM);
  assign underrun  = tick && (state == SHIFT) && empty && !hold_full;
  assign reload    = tick && (state == SHIFT) && !empty && (idx == 3'd7) && !cur_last && hold_full;
  assign consume   = reload || (tick && (state == SHIFT) && empty && hold_full)
                     || ((state == IDLE) && hold_full);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold       <= '0;
      hold_last  <= 1'b0;
      hold_full  <= 1'b0;
      sh         <= '0;
      idx        <= '0;
      cur_last   <= 1'b0;
      empty      <= 1'b0;
      last_taken <= 1'b0;
      final_sent <= 1'b0;
      ones       <= '0;
      div        <= '0;
      bit_valid  <= 1'b0;
      bit_out    <= 1'b1;
      tx_active  <= 1'b0;
      tx_done    <= 1'b0;
      tx_err     <= 1'b0;
    end else begin
      bit_valid <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
      div       <= (state == IDLE || div == DIV_LAST) ? 5'd0 : div + 1'b1;

      if (accept && state != IDLE) begin
        hold      <= tx_data;
        hold_last <= tx_last;
        hold_full <= 1'b1;
      end else if (consume) begin
        hold_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          tx_active <= hold_full || accept;
          if (start) begin
            sh         <= hold_full ? hold : tx_data;
            cur_last   <= hold_full ? hold_last : tx_last;
            idx        <= '0;
            empty      <= 1'b0;
            ones       <= '0;
            final_sent <= 1'b0;
            state      <= SHIFT;
          end
        end
        SHIFT: if (tick) begin
          if (underrun) begin
            tx_err     <= 1'b1;
            last_taken <= 1'b0;
            state      <= IDLE;
          end else begin
            bit_valid <= 1'b1;
            bit_out   <= src[0];
            ones      <= ones_n;
            if (eff_idx == 3'd7) begin
              if (cur_last) begin
                final_sent <= 1'b1;
                state      <= stuff_now ? STUFF : FINISH;
              end else begin
                if (hold_full) begin
                  sh       <= hold;
                  cur_last <= hold_last;
                  idx      <= '0;
                end else begin
                  empty    <= 1'b1;
                end
                state <= stuff_now ? STUFF : SHIFT;
              end
            end else begin
              sh       <= {1'b0, src[7:1]};
              idx      <= eff_idx + 3'd1;
              cur_last <= src_last;
              empty    <= 1'b0;
              state    <= stuff_now ? STUFF : SHIFT;
            end
          end
        end
        STUFF: if (tick) begin
          bit_valid <= 1'b1;
          bit_out   <= 1'b0;
          ones      <= '0;
          state     <= final_sent ? FINISH : SHIFT;
        end
        FINISH: if (tick) begin
          tx_done    <= 1'b1;
          last_taken <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A final byte accepted on an underrun cycle must still block the next packet.
      if (accept && tx_last) last_taken <= 1'b1;
    end
  end

`ifdef USB_STUFF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stuff_cnt <= '0;
    end else if (start) begin
      stuff_cnt <= '0;
    end else if (state == STUFF && tick && stuff_cnt != 8'hFF) begin
      stuff_cnt <= stuff_cnt + 8'd1;
    end
  end
`endif

endmodule
